// File: rtl/qpsk_mapper_pkg.sv
// Shared WiMAX PHY types for the QPSK mapper: sample type, symbol payload, block sizing.
// Payload carries a block index only when QPSK_MAPPER_SYM_INDEX_EN is defined.
package wimax_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned IDX_W_MAX = 16;

  typedef logic signed [SAMPLE_W-1:0] iq_sample_t;

  // 0.7071 in Q1.15
  localparam iq_sample_t QPSK_AMP = 16'sh5A82;

  typedef struct packed {
    iq_sample_t i;
    iq_sample_t q;
    logic       last;
`ifdef QPSK_MAPPER_SYM_INDEX_EN
    logic [IDX_W_MAX-1:0] idx;
`endif
  } qpsk_sym_t;

  function automatic int unsigned syms_per_block(input int unsigned ncbps,
                                                 input int unsigned ncpc);
    return ncbps / ncpc;
  endfunction

endpackage

// File: rtl/qpsk_mapper_if.sv
// Bit-stream input and I/Q symbol output handshakes of the QPSK mapper.
// sym_index is present only when QPSK_MAPPER_SYM_INDEX_EN is defined.
interface qpsk_mapper_if #(
  parameter int unsigned IQ_W  = 16,
  parameter int unsigned Ncbps = 192
);
  localparam int unsigned IdxW = $clog2(Ncbps / 2);

  logic                   data_in;
  logic                   valid_in;
  logic                   ready_out;
  logic signed [IQ_W-1:0] i_out;
  logic signed [IQ_W-1:0] q_out;
  logic                   valid_out;
  logic                   ready_in;
  logic                   last_out;
`ifdef QPSK_MAPPER_SYM_INDEX_EN
  logic [IdxW-1:0]        sym_index;

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, i_out, q_out, valid_out, last_out, sym_index
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, i_out, q_out, valid_out, last_out, sym_index
  );
`else
  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, i_out, q_out, valid_out, last_out
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, i_out, q_out, valid_out, last_out
  );
`endif

endinterface

// File: rtl/qpsk_mapper_sym_fifo2.sv
// Generic 2-entry first-word-fall-through FIFO; slot0 is always the head.
// When drained, the head keeps the last popped entry.
module sym_fifo2 #(
  parameter type T = logic [7:0]
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output T           head,
  output logic [1:0] count
);

  T           slot0_q, slot0_d;
  T           slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);

    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data;
        end else begin
          slot1_d = push_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          slot0_d = slot1_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count unchanged; the older entry moves up behind the popped head.
        if (count_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end else begin
          slot0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

  no_overflow_a : assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == 2'd2) && !pop));

  head_stable_a : assert property (@(posedge clk) disable iff (reset)
    ((count_q != 2'd0) && !pop) |=> (slot0_q == $past(slot0_q)));

endmodule

// File: rtl/qpsk_mapper.sv
// WiMAX QPSK mapper: pairs interleaved bits into I/Q points, flags the last symbol of each block.
// Optional sym_index output enabled by QPSK_MAPPER_SYM_INDEX_EN.
module qpsk_mapper
  import wimax_pkg::*;
#(
  parameter int unsigned            Ncbps = 192,
  parameter int unsigned            Ncpc  = 2,
  parameter int unsigned            IQ_W  = 16,
  parameter logic signed [IQ_W-1:0] AMP   = 16'sh5A82
) (
  input logic           clk,
  input logic           reset,
  qpsk_mapper_if.slave  bus
);

  localparam int unsigned SymsPerBlock = syms_per_block(Ncbps, Ncpc);
  localparam int unsigned CntW         = (SymsPerBlock > 1) ? $clog2(SymsPerBlock) : 1;
  localparam iq_sample_t  AmpPos       = AMP;
  localparam iq_sample_t  AmpNeg       = -AMP;

  if (Ncpc != 2) begin : g_bad_ncpc
    $error("qpsk_mapper: Ncpc must be 2 for QPSK");
  end
  if ((Ncbps % 2) != 0 || Ncbps < 4) begin : g_bad_ncbps
    $error("qpsk_mapper: Ncbps must be even and at least 4");
  end
  if (IQ_W != SAMPLE_W) begin : g_bad_iq_w
    $error("qpsk_mapper: IQ_W must match wimax_pkg::SAMPLE_W");
  end
  if (CntW > IDX_W_MAX) begin : g_bad_idx_w
    $error("qpsk_mapper: symbol index does not fit the payload field");
  end

  typedef enum logic {StEven, StHalf} pair_state_e;

  pair_state_e     state_q, state_d;
  logic            b0_q, b0_d;
  logic [CntW-1:0] sym_cnt_q, sym_cnt_d;
  logic            bit_fire, push, pop, last_sym;
  logic [1:0]      fifo_count;
  qpsk_sym_t       push_sym, head_sym;

  assign pop           = bus.valid_out && bus.ready_in;
  assign bus.valid_out = (fifo_count != 2'd0);
  // A full FIFO still takes b1 when the head leaves in the same cycle.
  assign bus.ready_out = (state_q == StEven) || (fifo_count < 2'd2) ||
                         ((fifo_count == 2'd2) && pop);
  assign bit_fire      = bus.valid_in && bus.ready_out;
  assign last_sym      = (sym_cnt_q == CntW'(SymsPerBlock - 1));

  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    push    = 1'b0;
    unique case (state_q)
      StEven: begin
        if (bit_fire) begin
          b0_d    = bus.data_in;
          state_d = StHalf;
        end
      end
      StHalf: begin
        if (bit_fire) begin
          push    = 1'b1;
          state_d = StEven;
        end
      end
      default: state_d = StEven;
    endcase
  end

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    if (push) begin
      sym_cnt_d = last_sym ? '0 : sym_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    push_sym      = '0;
    push_sym.i    = b0_q ? AmpNeg : AmpPos;
    push_sym.q    = bus.data_in ? AmpNeg : AmpPos;
    push_sym.last = last_sym;
`ifdef QPSK_MAPPER_SYM_INDEX_EN
    push_sym.idx  = IDX_W_MAX'(sym_cnt_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEven;
      b0_q      <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      b0_q      <= b0_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  sym_fifo2 #(
    .T (qpsk_sym_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_sym),
    .pop       (pop),
    .head      (head_sym),
    .count     (fifo_count)
  );

  assign bus.i_out    = head_sym.i;
  assign bus.q_out    = head_sym.q;
  assign bus.last_out = head_sym.last;
`ifdef QPSK_MAPPER_SYM_INDEX_EN
  localparam int unsigned IdxW = $clog2(Ncbps / 2);
  assign bus.sym_index = head_sym.idx[IdxW-1:0];
`endif

  ready_indep_a : assert property (@(posedge clk) disable iff (reset)
    (state_q == StEven) |-> bus.ready_out);

  output_hold_a : assert property (@(posedge clk) disable iff (reset)
    (bus.valid_out && !bus.ready_in) |=> (bus.valid_out && $stable(head_sym)));

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper: mapping table, full block, backpressure, gaps, resets.
`timescale 1ns/1ps
module tb_qpsk_mapper;

  localparam int unsigned NCBPS = 192;
  localparam int unsigned SPB   = 96;
  localparam logic [15:0] POS   = 16'h5A82;
  localparam logic [15:0] NEG   = 16'hA57E;
  localparam logic [191:0] STREAM =
    192'h2833E48D_0123456789ABCDEF0123456789ABCDEF0123_48CA;

  typedef struct {
    bit          b0;
    bit          b1;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
    int          idx;
  } rx_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  logic  rdy_req = 1'b0;
  logic  rst_req = 1'b1;
  int    cyc = 0;
  int    accepted = 0;
  int    errors = 0;
  int    checks = 0;
  bit    tx_q[$];
  rx_t   rx_q[$];
  vec_t  vecs[4];
  logic [191:0] stream_v;

  qpsk_mapper_if #(.IQ_W(16), .Ncbps(NCBPS)) bus ();

  qpsk_mapper #(
    .Ncbps (NCBPS),
    .Ncpc  (2),
    .IQ_W  (16),
    .AMP   (16'sh5A82)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; handshakes are sampled at the negedge.
  task automatic tick();
    rx_t r;
    @(posedge clk);
    #1;
    cyc++;
    reset        = rst_req;
    bus.ready_in = rdy_req;
    if (tx_q.size() != 0) begin
      bus.valid_in = 1'b1;
      bus.data_in  = tx_q[0];
    end else begin
      bus.valid_in = 1'b0;
      bus.data_in  = 1'b0;
    end
    @(negedge clk);
    if (!reset && bus.valid_in && bus.ready_out) begin
      void'(tx_q.pop_front());
      accepted++;
    end
    if (!reset && bus.valid_out && bus.ready_in) begin
      r.cyc  = cyc;
      r.i    = $unsigned(bus.i_out);
      r.q    = $unsigned(bus.q_out);
      r.last = bus.last_out;
`ifdef QPSK_MAPPER_SYM_INDEX_EN
      r.idx  = int'(bus.sym_index);
`else
      r.idx  = -1;
`endif
      rx_q.push_back(r);
    end
  endtask

  task automatic do_reset();
    tx_q.delete();
    rst_req = 1'b1;
    tick();
    tick();
    rst_req = 1'b0;
    tick();
    rx_q.delete();
    accepted = 0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, rx_q.size(), n);
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (accepted < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, accepted, n);
  endtask

  task automatic load_stream(input int blocks);
    for (int b = 0; b < blocks; b++) begin
      for (int k = 0; k < NCBPS; k++) tx_q.push_back(stream_v[NCBPS-1-k]);
    end
  endtask

  initial begin
    int load_cyc;
    int nlast;
    bit bi, bq;

    stream_v = STREAM;
    vecs[0] = '{b0: 1'b0, b1: 1'b0, exp_i: POS, exp_q: POS};
    vecs[1] = '{b0: 1'b0, b1: 1'b1, exp_i: POS, exp_q: NEG};
    vecs[2] = '{b0: 1'b1, b1: 1'b0, exp_i: NEG, exp_q: POS};
    vecs[3] = '{b0: 1'b1, b1: 1'b1, exp_i: NEG, exp_q: NEG};
    bus.data_in  = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_ready_out", bus.ready_out, 1);
    chk("rst_i_out", $unsigned(bus.i_out), 0);
    chk("rst_q_out", $unsigned(bus.q_out), 0);
    chk("rst_last_out", bus.last_out, 0);
`ifdef QPSK_MAPPER_SYM_INDEX_EN
    chk("rst_sym_index", bus.sym_index, 0);
`endif

    // Mapping table
    rdy_req = 1'b1;
    for (int v = 0; v < 4; v++) begin
      rx_q.delete();
      tx_q.push_back(vecs[v].b0);
      tx_q.push_back(vecs[v].b1);
      wait_rx(1, 20, $sformatf("vec%0d_timeout", v));
      if (rx_q.size() != 0) begin
        chk($sformatf("vec%0d_i", v), rx_q[0].i, vecs[v].exp_i);
        chk($sformatf("vec%0d_q", v), rx_q[0].q, vecs[v].exp_q);
        chk($sformatf("vec%0d_last", v), rx_q[0].last, 0);
      end
    end

    // Full block, continuous valid/ready
    do_reset();
    load_cyc = cyc;
    load_stream(1);
    wait_rx(SPB, 500, "blk_timeout");
    repeat (4) tick();
    chk("blk_count", rx_q.size(), SPB);
    if (rx_q.size() == SPB) begin
      chk("blk_first_latency", rx_q[0].cyc, load_cyc + 3);
      chk("blk_sym0_i", rx_q[0].i, POS);
      chk("blk_sym0_q", rx_q[0].q, POS);
      chk("blk_sym1_i", rx_q[1].i, NEG);
      chk("blk_sym1_q", rx_q[1].q, POS);
      for (int k = 0; k < SPB; k++) begin
        bi = stream_v[NCBPS-1-2*k];
        bq = stream_v[NCBPS-2-2*k];
        chk($sformatf("blk_i[%0d]", k), rx_q[k].i, bi ? NEG : POS);
        chk($sformatf("blk_q[%0d]", k), rx_q[k].q, bq ? NEG : POS);
        chk($sformatf("blk_last[%0d]", k), rx_q[k].last, (k == SPB - 1));
        if (k > 0) chk($sformatf("blk_gap[%0d]", k), rx_q[k].cyc - rx_q[k-1].cyc, 2);
      end
    end

    // Backpressure from reset: 2 symbols + 1 held bit, then stall
    rdy_req = 1'b0;
    do_reset();
    tx_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    repeat (20) tick();
    chk("bp_accepted", accepted, 5);
    chk("bp_ready_low", bus.ready_out, 0);
    chk("bp_valid", bus.valid_out, 1);
    chk("bp_head_i", $unsigned(bus.i_out), POS);
    chk("bp_head_q", $unsigned(bus.q_out), NEG);
    repeat (5) tick();
    chk("bp_hold_i", $unsigned(bus.i_out), POS);
    chk("bp_hold_q", $unsigned(bus.q_out), NEG);
    chk("bp_hold_ready", bus.ready_out, 0);
    rdy_req = 1'b1;
    tick();
    chk("bp_pop_ready_same_cycle", bus.ready_out, 1);
    rdy_req = 1'b0;
    tick();
    chk("bp_push_pop_accepted", accepted, 6);
    chk("bp_after_valid", bus.valid_out, 1);
    chk("bp_after_head_i", $unsigned(bus.i_out), NEG);
    chk("bp_after_head_q", $unsigned(bus.q_out), NEG);
    rdy_req = 1'b1;
    repeat (8) tick();
    chk("bp_drain_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("bp_order0_q", rx_q[0].q, NEG);
      chk("bp_order1_i", rx_q[1].i, NEG);
      chk("bp_order1_q", rx_q[1].q, NEG);
      chk("bp_order2_i", rx_q[2].i, NEG);
      chk("bp_order2_q", rx_q[2].q, POS);
    end
    chk("bp_drained", bus.valid_out, 0);
    chk("bp_empty_hold_i", $unsigned(bus.i_out), NEG);

    // Idle gap while holding b0
    do_reset();
    tx_q.push_back(1'b1);
    wait_acc(1, 10, "gap_b0_timeout");
    repeat (10) tick();
    chk("gap_no_symbol", rx_q.size(), 0);
    chk("gap_valid_low", bus.valid_out, 0);
    tx_q.push_back(1'b1);
    wait_rx(1, 10, "gap_sym_timeout");
    repeat (3) tick();
    chk("gap_count", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      chk("gap_i", rx_q[0].i, NEG);
      chk("gap_q", rx_q[0].q, NEG);
    end

    // Reset mid-block with one symbol queued and one bit held
    rdy_req = 1'b0;
    do_reset();
    tx_q = '{1'b1, 1'b0, 1'b1};
    wait_acc(3, 20, "mid_acc_timeout");
    chk("mid_valid_before", bus.valid_out, 1);
    rdy_req = 1'b1;
    do_reset();
    chk("mid_valid_after", bus.valid_out, 0);
    chk("mid_ready_after", bus.ready_out, 1);
    chk("mid_i_after", $unsigned(bus.i_out), 0);
    load_stream(1);
    wait_rx(SPB, 500, "mid_blk_timeout");
    repeat (4) tick();
    chk("mid_blk_count", rx_q.size(), SPB);
    nlast = 0;
    foreach (rx_q[k]) if (rx_q[k].last) nlast++;
    chk("mid_nlast", nlast, 1);
    if (rx_q.size() == SPB) chk("mid_last95", rx_q[SPB-1].last, 1);
    if (rx_q.size() == SPB) chk("mid_sym0_i", rx_q[0].i, POS);

    // Two back-to-back blocks
    do_reset();
    load_stream(2);
    wait_rx(2 * SPB, 900, "two_blk_timeout");
    repeat (4) tick();
    chk("two_blk_count", rx_q.size(), 2 * SPB);
    if (rx_q.size() == 2 * SPB) begin
      for (int k = 0; k < 2 * SPB; k++) begin
        chk($sformatf("two_last[%0d]", k), rx_q[k].last, (k == SPB - 1) || (k == 2 * SPB - 1));
`ifdef QPSK_MAPPER_SYM_INDEX_EN
        chk($sformatf("two_idx[%0d]", k), rx_q[k].idx, k % SPB);
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qpsk_mapper.md
Name: qpsk_mapper

Overview:
- Modulation stage directly downstream of the interleaver in the WiMAX PHY transmit chain.
- Consumes the interleaved serial bit stream (1 bit/clk, valid/ready) and pairs bits into QPSK constellation points.
- Emits signed fixed-point I/Q symbols to the IFFT/subcarrier-allocation stage through a 2-entry output FIFO.
- Marks the last symbol of each OFDM block (Ncbps bits = Ncbps/2 symbols).

Parameters:
- Ncbps, 192, coded bits per OFDM symbol; must be even.
- Ncpc, 2, coded bits per carrier; fixed at 2 for QPSK, elaborated with an assertion.
- IQ_W, 16, width of each I/Q sample, signed Q1.(IQ_W-1).
- AMP, 16'sh5A82, constellation magnitude (0.7071 in Q1.15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- data_in  in  1  interleaved bit from the interleaver.
- valid_in  in  1  data_in valid (from interleaver valid_interleaver).
- ready_out  out  1  mapper can accept a bit (to interleaver ready_in).
- i_out  out  IQ_W  in-phase sample, signed.
- q_out  out  IQ_W  quadrature sample, signed.
- valid_out  out  1  i_out/q_out/last_out valid.
- ready_in  in  1  downstream accepts the symbol.
- last_out  out  1  high with the final symbol (index Ncbps/2-1) of a block.

Behaviour:
- Bit transfer when valid_in && ready_out; symbol transfer when valid_out && ready_in.
- Pair assembler has two states:
  - EVEN: no bit held. An accepted bit is stored as b0 -> HALF.
  - HALF: b0 held. An accepted bit b1 forms a symbol, pushes it into the FIFO -> EVEN.
- Mapping (802.16 QPSK, first bit to I): b0=0 -> I=+AMP, b0=1 -> I=-AMP; b1=0 -> Q=+AMP, b1=1 -> Q=-AMP.
- ready_out = (state==EVEN) || (fifo_count<2) || (fifo_count==2 && ready_in && valid_out).
  - Simultaneous push and pop at full is allowed.
  - ready_out never depends on valid_in.
- FIFO: 2 entries of {I,Q,last}, first-word fall-through.
  - valid_out = fifo_count!=0; outputs show the head entry.
  - Count update: push only +1, pop only -1, push+pop unchanged.
  - Head is held stable while valid_out && !ready_in.
- Latency: symbol is visible on valid_out the cycle after the b1 transfer (registered push).
- Symbol counter sym_cnt, 0..Ncbps/2-1, increments on push.
  - last flag = (sym_cnt==Ncbps/2-1); the counter wraps to 0 on that push.
- valid_in low in HALF: b0 is held indefinitely, with no timeout.
- Reset (any cycle, including mid-block): state=EVEN, fifo_count=0, sym_cnt=0, valid_out=0, last_out=0, i_out=0, q_out=0, ready_out=1 in the cycle after reset deasserts. A held b0 is discarded.
- Outputs of empty FIFO: i_out/q_out/last_out hold their last popped values; they are meaningful only with valid_out.

Optional Feature:
- Macro QPSK_MAPPER_SYM_INDEX_EN.
- Defined:
  - Adds output port sym_index (width $clog2(Ncbps/2)), carried through the FIFO with each symbol and valid with valid_out.
  - Equals the symbol's position in its block, 0..95 at defaults; reset value 0.
- Undefined: the port and its FIFO storage are absent; all other behaviour is identical.

Decomposition:
- Package wimax_pkg holds:
  - QPSK_AMP constant.
  - iq_sample_t (signed [IQ_W-1:0]).
  - qpsk_sym_t struct {i, q, last[, idx]}.
  - SYMS_PER_BLOCK = Ncbps/Ncpc function.
- One sub-module, sym_fifo2: generic 2-entry FWFT FIFO with push/pop/count, parameterised on the payload type. The mapper instantiates it with qpsk_sym_t.

Test Plan:
- Reset then feed the 192-bit stream 0x2833E48D...48CA with ready_in=1 and valid_in=1 continuously:
  - 96 symbols out, one per 2 clks.
  - First symbol bits 0,0 -> I=+0x5A82, Q=+0x5A82.
  - Second symbol 1,0 -> I=-0x5A82 (0xA57E), Q=+0x5A82.
  - last_out only on symbol 95.
- Backpressure: hold ready_in=0 from reset, stream bits:
  - Exactly 5 bits are accepted (2 full symbols + 1 held bit), then ready_out=0.
  - Head stays stable.
  - Raising ready_in for 1 clk pops one symbol, and ready_out returns high the same cycle.
- Full-FIFO simultaneous push/pop: fifo_count=2, state=HALF, valid_in=1, ready_in=1 -> bit accepted, count stays 2, order preserved.
- Idle gap in HALF: send bit 1, hold valid_in=0 for 10 clks, send 1 -> a single symbol I=-AMP, Q=-AMP.
- Reset mid-block after 3 bits (1 symbol in FIFO, 1 bit held):
  - Next cycle valid_out=0 and ready_out=1.
  - A new 192-bit block yields last_out on its 96th symbol.
- Two back-to-back blocks: last_out asserted on symbols 95 and 191 only; with QPSK_MAPPER_SYM_INDEX_EN, sym_index runs 0..95, 0..95.
